// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the LSU data RAM: access sizes, FSM states
// and the per-byte write-enable mask.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Bit of req_width that selects a zero-extended load.
  localparam int UNS_BIT = 2;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY
  } state_t;

  // Byte-enable mask for an access of 2^sz bytes starting at byte offset off.
  function automatic logic [7:0] byte_en(input logic [1:0] sz, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << sz)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/be_ram.sv
// Word array with per-byte write enables and a registered read port.
// There is no reset: the owner clears the contents with a write sweep.
module be_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [NB-1:0]         i_be,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // The read register only updates on a read, so the last word read stays put.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lsu_data_ram.sv
// Byte-addressed LSU data memory with valid/ready request and response ports,
// sized loads/stores, misalignment errors and a zero-fill sweep after reset.
module lsu_data_ram
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2 ** (ADDR_WIDTH - $clog2(DATA_WIDTH / 8))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_width,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  state_t             r_state;
  logic [IDX_W-1:0]   r_init_ptr;
  logic               r_init_done;
  logic               r_rsp_err;
  logic               r_rsp_ld;
  logic               r_rsp_uns;
  logic [1:0]         r_rsp_sz;
  logic [OFF_W-1:0]   r_rsp_off;

  logic               w_rsp_valid;
  logic               w_accept;
  logic               w_init;
  logic [1:0]         w_sz;
  logic [OFF_W-1:0]   w_off;
  logic [2:0]         w_off3;
  logic [2:0]         w_amask;
  logic [IDX_W-1:0]   w_idx;
  logic               w_err;
  logic [7:0]         w_be_full;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [NB-1:0]      w_ram_be;
  logic [IDX_W-1:0]   w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [DATA_WIDTH-1:0] w_shift;
  logic               w_unused;

  // Right-aligned value of 2^sz bytes, sign- or zero-extended to the word.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [1:0] sz, input logic uns);
    logic [DATA_WIDTH-1:0] r;
    logic s;
    int nbits;
    nbits = 8 << sz;
    if (nbits >= DATA_WIDTH) return d;
    s = uns ? 1'b0 : d[nbits-1];
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = (i < nbits) ? d[i] : s;
    return r;
  endfunction

  assign w_rsp_valid = (r_state == ST_BUSY);
  assign w_init      = (r_state == ST_INIT);
  assign req_ready   = r_init_done && (!w_rsp_valid || rsp_ready);
  assign w_accept    = req_valid && req_ready;

  assign w_sz      = req_width[1:0];
  assign w_off     = req_addr[OFF_W-1:0];
  assign w_off3    = 3'(w_off);
  assign w_idx     = req_addr[OFF_W +: IDX_W];
  assign w_amask   = 3'((4'd1 << w_sz) - 4'd1);
  assign w_err     = (|(w_off3 & w_amask)) || (w_sz == SZ_D && DATA_WIDTH == 32);
  assign w_be_full = byte_en(w_sz, w_off3);

  // The sweep owns the RAM port during INIT; requests cannot be accepted then.
  assign w_ram_we    = w_init || (w_accept && req_we && !w_err);
  assign w_ram_re    = w_accept && !req_we && !w_err;
  assign w_ram_be    = w_init ? '1 : w_be_full[NB-1:0];
  assign w_ram_addr  = w_init ? r_init_ptr : w_idx;
  assign w_ram_wdata = w_init ? '0 : (req_wdata << {w_off, 3'b000});

  be_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_init_ptr  <= '0;
      r_init_done <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_ld    <= 1'b0;
      r_rsp_uns   <= 1'b0;
      r_rsp_sz    <= SZ_B;
      r_rsp_off   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_ptr <= r_init_ptr + 1'b1;
          if (r_init_ptr == IDX_W'(DEPTH - 1)) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end
        end
        ST_IDLE: if (w_accept) r_state <= ST_BUSY;
        ST_BUSY: if (rsp_ready && !w_accept) r_state <= ST_IDLE;
        default: r_state <= ST_INIT;
      endcase
      if (w_accept) begin
        r_rsp_err <= w_err;
        r_rsp_ld  <= !req_we;
        r_rsp_uns <= req_width[UNS_BIT];
        r_rsp_sz  <= w_sz;
        r_rsp_off <= w_off;
      end
    end
  end

  assign w_shift   = w_ram_q >> {r_rsp_off, 3'b000};
  assign rsp_valid = w_rsp_valid;
  assign rsp_err   = w_rsp_valid && r_rsp_err;
  assign rsp_rdata = (w_rsp_valid && r_rsp_ld && !r_rsp_err) ?
                     extend(w_shift, r_rsp_sz, r_rsp_uns) : '0;
  assign init_done = r_init_done;

  assign w_unused = ^{req_addr, w_be_full};

endmodule

// File: tb/tb_lsu_data_ram.sv
// Bench for lsu_data_ram: directed scenarios plus random traffic against a
// byte-array reference model; a second 32-bit instance covers the illegal D size.
module tb_lsu_data_ram;

  localparam int AW = 8;
  localparam int DP = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_width;
  logic [AW-1:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err, init_done;
  logic [63:0] rsp_rdata;

  logic        s_req_valid, s_req_we, s_rsp_ready;
  logic [2:0]  s_req_width;
  logic [5:0]  s_req_addr;
  logic [31:0] s_req_wdata;
  logic        s_req_ready, s_rsp_valid, s_rsp_err, s_init_done;
  logic [31:0] s_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [DP*8];

  lsu_data_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_width(req_width), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );

  lsu_data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(16)) dut32 (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_we(s_req_we), .req_width(s_req_width), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .init_done(s_init_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
  endtask

  // Reference behaviour: a flat byte array indexed by (word mod DEPTH, offset).
  task automatic model_op(input logic we, input logic [2:0] w, input logic [AW-1:0] a,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int idx, off, nb;
    logic [63:0] v;
    idx = int'(a >> 3) % DP;
    off = int'(a[2:0]);
    nb  = 1 << w[1:0];
    rd  = 64'd0;
    er  = 1'b0;
    if (off % nb != 0) begin
      er = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[idx*8 + off + i] = wd[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[idx*8 + off + i];
      if (nb < 8 && !w[2] && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      rd = v;
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] w, input logic [AW-1:0] a,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er,
                      output logic ok);
    int t;
    ok = 1'b0;
    rd = 'x;
    er = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (req_ready) begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      ok = rsp_valid;
      rd = rsp_rdata;
      er = rsp_err;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic xfer32(input logic we, input logic [2:0] w, input logic [5:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output logic ok);
    int t;
    ok = 1'b0;
    rd = 'x;
    er = 1'bx;
    @(negedge clk);
    s_req_valid = 1'b1; s_req_we = we; s_req_width = w; s_req_addr = a; s_req_wdata = wd;
    t = 0;
    while (!s_req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (s_req_ready) begin
      @(posedge clk);
      #1 s_req_valid = 1'b0;
      @(negedge clk);
      ok = s_rsp_valid;
      rd = s_rsp_rdata;
      er = s_rsp_err;
    end else begin
      s_req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_width = 3'd0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_width = 3'd0; s_req_addr = '0;
    s_req_wdata = '0; s_rsp_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, init_done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: {ready,valid,err,done}=%b expected 0000",
               {req_ready, rsp_valid, rsp_err, init_done});
    end
    n_cmp++;
    if (rsp_rdata !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
    end
  endtask

  // Releases reset and checks init_done rises exactly DP edges later.
  task automatic release_and_sweep(input string tag);
    logic early;
    early = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    for (int e = 1; e <= DP; e++) begin
      @(negedge clk);
      if (e < DP && (init_done !== 1'b0 || req_ready !== 1'b0)) early = 1'b1;
    end
    n_cmp++;
    if (early) begin
      n_bad++;
      $display("FAIL %s_early: init_done/req_ready high before %0d edges got 1 expected 0", tag, DP);
    end
    n_cmp++;
    if (init_done !== 1'b1 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done: init_done=%b req_ready=%b expected 1 1", tag, init_done, req_ready);
    end
  endtask

  task automatic test_init();
    logic [63:0] rd;
    logic er, ok;
    release_and_sweep("init");
    for (int i = 0; i < DP; i++) begin
      xfer(1'b0, 3'b011, AW'(i * 8), 64'd0, rd, er, ok);
      n_cmp++;
      if (!ok || er !== 1'b0 || rd !== 64'd0) begin
        n_bad++;
        $display("FAIL init_ld word %0d: ok=%b err=%b rdata=%h expected 1 0 0", i, ok, er, rd);
      end
    end
  endtask

  task automatic test_byte();
    logic [63:0] rd, mrd;
    logic er, ok, mer;
    xfer(1'b1, 3'b000, 8'h13, 64'hA5, rd, er, ok);
    model_op(1'b1, 3'b000, 8'h13, 64'hA5, mrd, mer);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 64'd0) begin
      n_bad++;
      $display("FAIL sb: ok=%b err=%b rdata=%h expected 1 0 0", ok, er, rd);
    end
    xfer(1'b0, 3'b000, 8'h13, 64'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 64'hFFFF_FFFF_FFFF_FFA5) begin
      n_bad++;
      $display("FAIL lb: err=%b rdata=%h expected 0 ffffffffffffffa5", er, rd);
    end
    xfer(1'b0, 3'b100, 8'h13, 64'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 64'h0000_0000_0000_00A5) begin
      n_bad++;
      $display("FAIL lbu: err=%b rdata=%h expected 0 a5", er, rd);
    end
    xfer(1'b0, 3'b011, 8'h10, 64'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 64'h0000_0000_A500_0000) begin
      n_bad++;
      $display("FAIL ld: err=%b rdata=%h expected 0 00000000a5000000", er, rd);
    end
  endtask

  task automatic test_misalign();
    logic [63:0] rd, mrd;
    logic er, ok, mer;
    xfer(1'b1, 3'b001, 8'h11, 64'hBEEF, rd, er, ok);
    model_op(1'b1, 3'b001, 8'h11, 64'hBEEF, mrd, mer);
    n_cmp++;
    if (!ok || er !== 1'b1 || rd !== 64'd0) begin
      n_bad++;
      $display("FAIL sh_mis: err=%b rdata=%h expected 1 0", er, rd);
    end
    xfer(1'b0, 3'b011, 8'h10, 64'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 64'h0000_0000_A500_0000) begin
      n_bad++;
      $display("FAIL sh_mis_unchanged: rdata=%h expected 00000000a5000000", rd);
    end
    xfer(1'b0, 3'b010, 8'h12, 64'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b1 || rd !== 64'd0) begin
      n_bad++;
      $display("FAIL lw_mis: err=%b rdata=%h expected 1 0", er, rd);
    end
  endtask

  task automatic test_dw32();
    logic [31:0] rd;
    logic er, ok;
    xfer32(1'b0, 3'b011, 6'h00, 32'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b1 || rd !== 32'd0) begin
      n_bad++;
      $display("FAIL dw32_ld: ok=%b err=%b rdata=%h expected 1 1 0", ok, er, rd);
    end
    xfer32(1'b1, 3'b000, 6'h05, 32'h80, rd, er, ok);
    xfer32(1'b0, 3'b000, 6'h05, 32'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'hFFFF_FF80) begin
      n_bad++;
      $display("FAIL dw32_lb: err=%b rdata=%h expected 0 ffffff80", er, rd);
    end
    xfer32(1'b0, 3'b010, 6'h04, 32'd0, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'h0000_8000) begin
      n_bad++;
      $display("FAIL dw32_lw: err=%b rdata=%h expected 0 00008000", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, mrd;
    logic er, ok, mer;
    int t;
    xfer(1'b1, 3'b010, 8'h08, 64'h8000_0001, rd, er, ok);
    model_op(1'b1, 3'b010, 8'h08, 64'h8000_0001, mrd, mer);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 8'h08;
    rsp_ready = 1'b0;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_accept: req_ready=%b expected 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 64'h77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'hFFFF_FFFF_8000_0001) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: valid=%b err=%b rdata=%h expected 1 0 ffffffff80000001",
                 c, rsp_valid, rsp_err, rsp_rdata);
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_ready c%0d: req_ready=%b expected 0", c, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: rsp_valid=%b expected 0", rsp_valid);
    end
    xfer(1'b0, 3'b010, 8'h20, 64'd0, rd, er, ok);
    model_op(1'b0, 3'b010, 8'h20, 64'd0, mrd, mer);
    n_cmp++;
    if (!ok || er !== mer || rd !== mrd) begin
      n_bad++;
      $display("FAIL bp_no_write: rdata=%h err=%b expected %h %b", rd, er, mrd, mer);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_rd, mrd;
    logic exp_er, mer;
    rsp_ready = 1'b1;
    exp_rd = '0;
    exp_er = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== exp_er || rsp_rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL b2b rsp%0d: valid=%b err=%b rdata=%h expected 1 %b %h",
                   k - 1, rsp_valid, rsp_err, rsp_rdata, exp_er, exp_rd);
        end
      end
      if (k < 8) begin
        n_cmp++;
        if (req_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b ready%0d: req_ready=%b expected 1", k, req_ready);
        end
        req_valid = 1'b1;
        req_we = (k % 2 == 0);
        req_width = 3'b010;
        req_addr = 8'h18;
        req_wdata = 64'h1000_0000 + 64'(k);
        model_op(req_we, req_width, req_addr, req_wdata, mrd, mer);
        exp_rd = mrd;
        exp_er = mer;
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] mrd;
    logic mer;
    int t;
    model_op(1'b0, 3'b011, 8'h10, 64'd0, mrd, mer);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b011; req_addr = 8'h10;
    rsp_ready = 1'b0;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== mrd) begin
      n_bad++;
      $display("FAIL arst_pre: valid=%b rdata=%h expected 1 %h", rsp_valid, rsp_rdata, mrd);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, init_done} !== 4'b0000 || rsp_rdata !== 64'd0) begin
      n_bad++;
      $display("FAIL arst_clear: {ready,valid,err,done}=%b rdata=%h expected 0000 0",
               {req_ready, rsp_valid, rsp_err, init_done}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    release_and_sweep("arst");
  endtask

  task automatic test_random();
    logic [63:0] rd, mrd, wd;
    logic er, ok, mer, we;
    logic [2:0] w;
    logic [AW-1:0] a;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      w  = 3'($urandom_range(0, 7));
      a  = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a = a & ~AW'((1 << w[1:0]) - 1);
      wd = {$urandom, $urandom};
      xfer(we, w, a, wd, rd, er, ok);
      model_op(we, w, a, wd, mrd, mer);
      n_cmp++;
      if (!ok || er !== mer || rd !== mrd) begin
        n_bad++;
        $display("FAIL rand%0d we=%b w=%b a=%h: ok=%b err=%b rdata=%h expected 1 %b %h",
                 n, we, w, a, ok, er, rd, mer, mrd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte();
    test_misalign();
    test_dw32();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_data_ram.md
# lsu_data_ram

Parametrised, byte-addressed data memory for the load/store stage, replacing the single-width word array with a valid/ready request/response port. Supports byte/half/word/double accesses with per-lane write enables, sign/zero-extended loads and misalignment errors. A hardware zero-fill sweep runs after reset. Sits between the LSU and the writeback mux; one access per cycle, one-cycle read latency.

## Interface
- `DATA_WIDTH`, default 64: word width in bits; legal values are 32 or 64.
- `ADDR_WIDTH`, default 12: byte-address width.
- `DEPTH`, default 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)): number of words; must not exceed the address range.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid` and `req_ready` are both high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_width` in 3: `[1:0]` size (0 = B, 1 = H, 2 = W, 3 = D); `[2]` = unsigned load. Bit 2 is ignored on stores and for D.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-aligned (byte 0 = bits [7:0]).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid` and `rsp_ready` are both high.
- `rsp_rdata` out DATA_WIDTH: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal-size access.
- `init_done` out 1: zero-fill sweep complete.

## Operation
- **FSM states:** INIT, IDLE, BUSY.
  - Reset enters INIT.
  - INIT writes 0 to word `init_ptr` each cycle, with `init_ptr` counting 0..DEPTH−1. On the last word it moves to IDLE and sets `init_done`.
  - In IDLE, an accepted request moves to BUSY. In BUSY, a response handshake with no new request returns to IDLE. A response handshake together with a new request stays in BUSY.
- `req_ready = init_done && (!rsp_valid || rsp_ready)`. The response register holds a single entry.
- **Word index and lanes:**
  - Word index = `req_addr >> log2(DATA_WIDTH/8)`.
  - Lane offset = low address bits.
  - Alignment rule: offset must be a multiple of 2^size.
- **Error cases:** size 3 with DATA_WIDTH=32 is illegal. A misaligned or illegal access does not modify memory; it returns `rsp_err=1` and `rsp_rdata=0`.
- **Store:**
  - Byte enable = (2^(2^size) − 1) << offset.
  - Write data = `req_wdata << (8·offset)`.
  - Only enabled bytes change.
  - The response has `rsp_err=0` and `rsp_rdata=0`.
- **Load:**
  - Select 2^size bytes starting at the offset and right-align them.
  - Zero-extend if `req_width[2]` is set, otherwise sign-extend from the top selected bit.
  - D loads return the whole word.
- **Addressing limits:**
  - A word index ≥ DEPTH wraps modulo DEPTH. DEPTH must be a power of two.
  - Addresses never wrap across a word boundary, because misaligned accesses are rejected.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `init_done=0`, state INIT, `init_ptr=0`.
- **Init sweep:** the first sweep write occurs on the first edge after `rst` deasserts. `init_done` rises after DEPTH edges.
- **Latency:** a request accepted at edge N has its response valid after edge N, with the result visible in cycle N+1.
- **Throughput:** one access per cycle while `rsp_ready=1`.
- **Back-pressure:** while `rsp_valid && !rsp_ready`, `rsp_*` hold stable, `req_ready=0`, and memory is not modified.
- **Ordering:** a load accepted the cycle after a store to the same word returns the new data. There is no same-cycle conflict because only one port exists.
- **Reset mid-operation:** asserting `rst` at any point immediately clears all outputs and restarts INIT from `init_ptr=0`. A pending response is discarded.

## Structure
- **Shared package `lsu_pkg`:**
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`.
  - Unsigned-bit index.
  - FSM state encoding.
  - Byte-enable helper function.
- **Sub-module `be_ram`:** DEPTH×DATA_WIDTH array, synchronous write with per-byte enable, synchronous read. It has no reset; clearing is done by the sweep.
- **Top level:** FSM, init counter, alignment check, lane shift and extension logic, response register.

## Test plan
- **Init sweep:** DEPTH=16, DATA_WIDTH=64; release `rst`. Expect `init_done` high exactly after 16 edges and `req_ready` low before that. Loads of D from every word then return 0.
- **Byte store/load:**
  - SB 0xA5 to addr 0x13 → `rsp_err=0`.
  - LB from 0x13 → 0xFFFF_FFFF_FFFF_FFA5.
  - LBU from 0x13 → 0x0000_0000_0000_00A5.
  - LD from 0x10 → 0x0000_0000_A500_0000.
- **Misalignment:**
  - SH to 0x11 → `rsp_err=1`; memory unchanged.
  - LW to 0x12 → `rsp_err=1`, `rsp_rdata=0`.
  - With DATA_WIDTH=32, LD to 0x0 → `rsp_err=1`.
- **Back-pressure:** issue LW 0x8 (holding 0x8000_0001), then hold `rsp_ready=0` for 3 cycles. `rsp_rdata` must hold 0xFFFF_FFFF_8000_0001, `req_ready` must stay 0, and a pending store must not be written until the handshake.
- **Streaming:** with `rsp_ready=1`, issue 8 back-to-back alternating SW/LW to the same address with incrementing data. Expect one response per cycle, each load returning the immediately preceding store's value.
- **Async reset mid-stream:** assert `rst` low between edges while `rsp_valid=1`. Outputs clear without a clock edge, and after release INIT restarts with `init_done` again DEPTH edges later.
